// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed store/load slave with programmable wait states.
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after the acceptance edge; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready is seen.
//
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready handshake with req_write, req_addr (byte address), req_wdata, req_be
//   rsp_valid/rsp_ready handshake with rsp_rdata, rsp_err
//   busy: high whenever the FSM is not IDLE
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Last counter value spent in WAIT; unused when there are no wait states.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        req_write_q, req_write_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_be_q, req_be_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_d [DEPTH_WORDS];

    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   merged_word;

    // Error decode works on the latched address so req_* may change freely while busy.
    assign idx      = req_addr_q[AW+1:2];
    assign addr_err = (req_addr_q[1:0] != 2'b00) || (req_addr_q[31:AW+2] != '0);

    // Byte-merge of the store data into the currently stored word.
    always_comb begin
        merged_word = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (req_be_q[b]) begin
                merged_word[8*b +: 8] = req_wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_be_d    = req_be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_d       = mem_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_write_d = req_write;
                    req_addr_d  = req_addr;
                    req_wdata_d = req_wdata;
                    req_be_d    = req_be;
                    wait_cnt_d  = 4'd0;
                    state_d     = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = S_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_ACCESS: begin
                rsp_err_d   = addr_err;
                rsp_rdata_d = '0;
                if (!addr_err) begin
                    if (req_write_q) begin
                        mem_d[idx] = merged_word;
                    end else begin
                        rsp_rdata_d = mem_q[idx];
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_be_q    <= req_be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Handshake outputs depend only on state, so they drop with reset and never
    // follow the opposite-side valid/ready combinationally.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    // Instance A: default two wait states
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    // Instance B: zero wait states
    logic        req_valid_b, req_ready_b, req_write_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic [3:0]  req_be_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
    logic [31:0] rsp_rdata_b;

    int n_vec;
    int n_fail;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction on instance A starting #1 after a rising edge with A idle.
    // Returns the response fields, the number of edges from the acceptance edge
    // (inclusive) up to the one after which rsp_valid was seen (0 on timeout),
    // and how many waiting cycles showed busy low.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat, output int busy_low);
        int edges;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b0;
        busy_low  = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'h0BAD_0BAD;
        req_addr  = 32'h0000_0000;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
            edges++;
        end
        lat   = rsp_valid ? edges : 0;
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
        req_valid_b = 0; req_write_b = 0; req_addr_b = 0; req_wdata_b = 0; req_be_b = 0;
        rsp_ready_b = 0;
        #23;
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; int bl;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, bl);
        n_vec++; if (lat !== 4) begin n_fail++; $display("FAIL store_latency got %0d exp 4", lat); end
        n_vec++; if (bl !== 0) begin n_fail++; $display("FAIL store_busy_low got %0d exp 0", bl); end
        n_vec++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got %b exp 0", er); end
        n_vec++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata got %h exp 0", rd); end
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL store_idle_after got %b exp 1", req_ready); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_0x10 got %h exp deadbeef", rd); end
        n_vec++; if (lat !== 4) begin n_fail++; $display("FAIL load_latency got %0d exp 4", lat); end
        do_req(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'h0) begin n_fail++; $display("FAIL load_cleared got %h exp 0", rd); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic er; int lat; int bl;
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, bl);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, bl);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge got %h exp 11bb33dd", rd); end
        // be = 0 store is a legal no-op
        do_req(1'b1, 32'h10, 32'h12345678, 4'b0000, rd, er, lat, bl);
        n_vec++; if (er !== 1'b0) begin n_fail++; $display("FAIL be_zero_err got %b exp 0", er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL be_zero_noop got %h exp deadbeef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int bl;
        do_req(1'b0, 32'h402, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned got %b exp 1", er); end
        n_vec++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_misaligned_rdata got %h exp 0", rd); end
        do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, bl);
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat, bl);
        n_vec++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_oor_store got %b exp 1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_oor_untouched got %h exp cafef00d", rd); end
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_top_word got %b exp 0", er); end
        do_req(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, er, lat, bl);
        n_vec++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned_store got %b exp 1", er); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_misaligned_untouched got %h exp deadbeef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int bl; int edges;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        edges = 1;
        while (!rsp_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_vec++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout got %b exp 1", rsp_valid); end
        for (int c = 0; c < 5; c++) begin
            // A store request pulsed during the stall must be ignored.
            if (c == 2) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
                req_wdata = 32'h0; req_be = 4'hF;
            end else begin
                req_valid = 1'b0;
            end
            n_vec++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, rsp_valid); end
            n_vec++; if (rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata cyc %0d got %h exp deadbeef", c, rsp_rdata); end
            n_vec++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready cyc %0d got %b exp 0", c, req_ready); end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", rsp_valid); end
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle got %b exp 1", req_ready); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_pulse_ignored got %h exp deadbeef", rd); end
    endtask

    task automatic test_zero_wait();
        logic exp_vld, exp_rdy;
        rsp_ready_b = 1'b1;
        req_valid_b = 1'b1;
        req_write_b = 1'b0;
        req_addr_b  = 32'h8;
        // After edge k: ACCESS, RESP, IDLE repeating (accept on edges 1, 4, 7).
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            exp_vld = (k % 3 == 2);
            exp_rdy = (k % 3 == 0);
            n_vec++; if (rsp_valid_b !== exp_vld) begin n_fail++; $display("FAIL zw_rsp_valid edge %0d got %b exp %b", k, rsp_valid_b, exp_vld); end
            n_vec++; if (req_ready_b !== exp_rdy) begin n_fail++; $display("FAIL zw_req_ready edge %0d got %b exp %b", k, req_ready_b, exp_rdy); end
        end
        req_valid_b = 1'b0;
        rsp_ready_b = 1'b0;
        n_vec++; if (rsp_err_b !== 1'b0) begin n_fail++; $display("FAIL zw_err got %b exp 0", rsp_err_b); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int bl;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
        req_wdata = 32'h12345678; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_in_wait got %b exp 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, bl);
        n_vec++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_store_aborted got %h exp 0", rd); end
        n_vec++; if (lat !== 4) begin n_fail++; $display("FAIL mid_load_latency got %0d exp 4", lat); end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_zero_wait();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
